// File: rtl/pb_arb_pkg.sv
// Shared types and default sizing for the pushbutton pulse arbiter.
package pb_arb_pkg;

    // Per-button one-pulser state encoding.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        HELD  = 2'd2
    } pb_state_e;

    localparam int PB_N_BTN_DEF     = 4;
    localparam int PB_DB_CYCLES_DEF = 16;

endpackage

// File: rtl/pb_debounce_pulse.sv
// One pushbutton channel: 2-FF synchroniser, debounce filter and one-pulser.
//
//  state | meaning
//  IDLE  | debounced level low, waiting for a press
//  PULSE | press just accepted, emit the single press event
//  HELD  | button still down, wait for debounced release
//
// The press output is taken from a flop one cycle after PULSE so the
// pending-flag logic in the top sees a clean registered event.
module pb_debounce_pulse
    import pb_arb_pkg::*;
#(
    parameter int DB_CYCLES = PB_DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pb,
    output logic press
);

    localparam int CNT_W = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             stable_q;
    logic [CNT_W-1:0] cnt_q;
    pb_state_e        state_q;
    pb_state_e        state_d;
    logic             press_q;

    // Two-stage synchroniser for the asynchronous button level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b00;
        else        sync_q <= {sync_q[0], pb};
    end

    // Accept a level change only after it persists for DB_CYCLES samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else if (sync_q[1] != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_q <= sync_q[1];
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else begin
            cnt_q <= '0;
        end
    end

    // State register plus registered press event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            press_q <= 1'b0;
        end else begin
            state_q <= state_d;
            press_q <= (state_q == PULSE);
        end
    end

    // One-pulser next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (stable_q) state_d = PULSE;
            PULSE:   state_d = HELD;
            HELD:    if (!stable_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign press = press_q;

endmodule

// File: rtl/pb_pulse_arbiter.sv
// Pushbutton front panel: per-button press events queued as pending flags,
// granted round-robin onto a valid/ready command port.
// Optional feature macro: PB_ARB_OVERRUN_EN adds a sticky per-button
// overrun flag for presses merged into an already pending request.
module pb_pulse_arbiter
    import pb_arb_pkg::*;
#(
    parameter int  N_BTN     = PB_N_BTN_DEF,
    parameter int  DB_CYCLES = PB_DB_CYCLES_DEF,
    localparam int ID_W      = $clog2(N_BTN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] pb,
    output logic             cmd_valid,
    output logic [ID_W-1:0]  cmd_id,
    input  logic             cmd_ready,
`ifdef PB_ARB_OVERRUN_EN
    output logic [N_BTN-1:0] overrun,
`endif
    output logic             busy
);

    logic [N_BTN-1:0] press;
    logic [N_BTN-1:0] pending_q, pending_d;
    logic [N_BTN-1:0] grant_clr;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]  cmd_id_q, cmd_id_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic [ID_W-1:0]  grant_idx;
    logic [ID_W-1:0]  scan_cand;
    logic             grant_found;
    logic             load;
    int               scan_idx;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        pb_debounce_pulse #(
            .DB_CYCLES(DB_CYCLES)
        ) u_btn (
            .clk   (clk),
            .rst_n (rst_n),
            .pb    (pb[i]),
            .press (press[i])
        );
    end

    // Round-robin scan: first pending index starting at rr_ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        scan_cand   = '0;
        for (int k = 0; k < N_BTN; k++) begin
            scan_idx = int'(rr_ptr_q) + k;
            if (scan_idx >= N_BTN) scan_idx = scan_idx - N_BTN;
            scan_cand = ID_W'(scan_idx);
            if (!grant_found && pending_q[scan_cand]) begin
                grant_found = 1'b1;
                grant_idx   = scan_cand;
            end
        end
    end

    // Output register load, pointer advance and pending update (set wins).
    always_comb begin
        load        = !cmd_valid_q || cmd_ready;
        cmd_valid_d = cmd_valid_q;
        cmd_id_d    = cmd_id_q;
        rr_ptr_d    = rr_ptr_q;
        grant_clr   = '0;
        if (load) begin
            if (grant_found) begin
                cmd_valid_d          = 1'b1;
                cmd_id_d             = grant_idx;
                grant_clr[grant_idx] = 1'b1;
                rr_ptr_d = (grant_idx == ID_W'(N_BTN - 1)) ? '0 : grant_idx + 1'b1;
            end else begin
                cmd_valid_d = 1'b0;
            end
        end
        pending_d = (pending_q & ~grant_clr) | press;
    end

    // Arbiter and command port registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= '0;
            rr_ptr_q    <= '0;
            cmd_valid_q <= 1'b0;
            cmd_id_q    <= '0;
        end else begin
            pending_q   <= pending_d;
            rr_ptr_q    <= rr_ptr_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_id_q    <= cmd_id_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_id    = cmd_id_q;
    assign busy      = (|pending_q) | cmd_valid_q;

`ifdef PB_ARB_OVERRUN_EN
    logic [N_BTN-1:0] overrun_q;

    // Sticky flag: a press landed on a request that was still waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) overrun_q <= '0;
        else        overrun_q <= overrun_q | (press & pending_q & ~grant_clr);
    end

    assign overrun = overrun_q;
`endif

endmodule

// File: tb/tb_pb_pulse_arbiter.sv
// Directed bench for pb_pulse_arbiter with N_BTN=4, DB_CYCLES=4.
module tb_pb_pulse_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] pb = 4'b0000;
    logic       cmd_ready = 1'b1;
    logic       cmd_valid;
    logic [1:0] cmd_id;
    logic       busy;
`ifdef PB_ARB_OVERRUN_EN
    logic [3:0] overrun;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;
    int xfer_q[$];
    logic any_high;

    pb_pulse_arbiter #(
        .N_BTN     (4),
        .DB_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pb        (pb),
        .cmd_valid (cmd_valid),
        .cmd_id    (cmd_id),
        .cmd_ready (cmd_ready),
`ifdef PB_ARB_OVERRUN_EN
        .overrun   (overrun),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Record every accepted command id, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && cmd_valid && cmd_ready) xfer_q.push_back(int'(cmd_id));
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int xfer_at(input int i);
        return (xfer_q.size() > i) ? xfer_q[i] : -1;
    endfunction

    initial begin
        // 1: reset, idle for 20 cycles
        tick(3);
        rst_n = 1'b1;
        any_high = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick(1);
            if (cmd_valid || busy) any_high = 1'b1;
        end
        check("idle_valid_busy", int'(any_high), 0);
        check("reset_cmd_id", int'(cmd_id), 0);
        check("idle_no_xfer", xfer_q.size(), 0);

        // 2: pb[2] held 50 cycles, first command after edge 9
        xfer_q.delete();
        pb[2] = 1'b1;
        tick(9);
        check("lat_edge8_valid", int'(cmd_valid), 0);
        tick(1);
        check("lat_edge9_valid", int'(cmd_valid), 1);
        check("lat_edge9_id", int'(cmd_id), 2);
        tick(40);
        pb[2] = 1'b0;
        tick(20);
        check("hold_xfer_count", xfer_q.size(), 1);
        check("hold_xfer_id", xfer_at(0), 2);
        check("hold_busy", int'(busy), 0);

        // 3: short pulse and bounce are filtered
        xfer_q.delete();
        pb[1] = 1'b1; tick(3);
        pb[1] = 1'b0; tick(1);
        pb[1] = 1'b1; tick(1);
        pb[1] = 1'b0; tick(1);
        pb[1] = 1'b1; tick(1);
        pb[1] = 1'b0; tick(20);
        check("glitch_xfer_count", xfer_q.size(), 0);
        check("glitch_busy", int'(busy), 0);

        // 4: all buttons at once from rr_ptr=0
        rst_n = 1'b0; tick(2);
        rst_n = 1'b1; tick(2);
        xfer_q.delete();
        pb = 4'b1111;
        tick(10);
        check("rr_valid_0", int'(cmd_valid), 1);
        check("rr_id_0", int'(cmd_id), 0);
        tick(1);
        check("rr_id_1", int'(cmd_id), 1);
        tick(1);
        check("rr_id_2", int'(cmd_id), 2);
        tick(1);
        check("rr_id_3", int'(cmd_id), 3);
        check("rr_busy_last", int'(busy), 1);
        tick(1);
        check("rr_valid_after", int'(cmd_valid), 0);
        check("rr_busy_after", int'(busy), 0);
        pb = 4'b0000;
        tick(20);
        check("rr_xfer_count", xfer_q.size(), 4);
        for (int i = 0; i < 4; i++) check("rr_xfer_order", xfer_at(i), i);

        // 5: backpressure, held command and merged press
        xfer_q.delete();
        cmd_ready = 1'b0;
        pb[3] = 1'b1;
        tick(10);
        check("bp_valid", int'(cmd_valid), 1);
        check("bp_id", int'(cmd_id), 3);
        tick(10);
        check("bp_hold_valid", int'(cmd_valid), 1);
        check("bp_hold_id", int'(cmd_id), 3);
        pb[3] = 1'b0; tick(10);
        pb[3] = 1'b1; tick(12);
        pb[3] = 1'b0; tick(10);
        check("bp_second_hold_id", int'(cmd_id), 3);
        check("bp_second_busy", int'(busy), 1);
        pb[3] = 1'b1; tick(12);
        pb[3] = 1'b0; tick(10);
`ifdef PB_ARB_OVERRUN_EN
        check("bp_overrun", int'(overrun), 4'b1000);
`endif
        check("bp_no_xfer_yet", xfer_q.size(), 0);
        cmd_ready = 1'b1;
        tick(6);
        check("bp_xfer_count", xfer_q.size(), 2);
        check("bp_xfer_0", xfer_at(0), 3);
        check("bp_xfer_1", xfer_at(1), 3);
        check("bp_valid_end", int'(cmd_valid), 0);
        check("bp_busy_end", int'(busy), 0);

        // 6: reset while a command is held and pb[0] is down
        cmd_ready = 1'b0;
        pb[0] = 1'b1;
        tick(10);
        check("rst_pre_valid", int'(cmd_valid), 1);
        check("rst_pre_id", int'(cmd_id), 0);
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", int'(cmd_valid), 0);
        check("rst_async_busy", int'(busy), 0);
        tick(2);
        rst_n = 1'b1;
        cmd_ready = 1'b1;
        xfer_q.delete();
        tick(9);
        check("rst_edge8_valid", int'(cmd_valid), 0);
        tick(1);
        check("rst_edge9_valid", int'(cmd_valid), 1);
        check("rst_edge9_id", int'(cmd_id), 0);
        tick(20);
        pb[0] = 1'b0;
        tick(20);
        check("rst_xfer_count", xfer_q.size(), 1);
        check("rst_xfer_id", xfer_at(0), 0);
        check("rst_busy_end", int'(busy), 0);
`ifdef PB_ARB_OVERRUN_EN
        check("rst_overrun_clear", int'(overrun), 0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
